// File: rtl/uart_cmd_ram.sv
// Command engine between UART RX and TX: parses 'W'/'R' commands (opcode, addr, len, payload)
// against an internal byte RAM and streams readback bytes out under valid/ready.
module uart_cmd_ram #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 25000
) (
    input  logic       ext_clk_25m,
    input  logic       ext_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       cmd_err
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam int unsigned TmoW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetLen,
        StWrData,
        StRdFetch,
        StRdWait,
        StRdSend
    } state_e;

    state_e              state_q, state_d;
    logic                is_rd_q, is_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                cmd_err_q, err_d;
    logic                busy_q;

    logic                tmo_run;
    logic                tmo_hit;
    logic                ram_we;
    logic                ram_re;
    logic [7:0]          rd_data_q;
    logic [7:0]          mem_q [Depth];

    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        tmo_run = (state_q == StGetAddr) || (state_q == StGetLen) || (state_q == StWrData);
        // An arriving byte always beats an expiring timeout.
        tmo_hit = tmo_run && !rx_valid && (tmo_q == TmoLast);
        tmo_d   = (rx_valid || !tmo_run || tmo_hit) ? '0 : tmo_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == OpWrite || rx_data == OpRead) begin
                        is_rd_d = (rx_data == OpRead);
                        state_d = StGetAddr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGetAddr: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_W-1:0];
                    state_d = StGetLen;
                end
            end
            StGetLen: begin
                if (rx_valid) begin
                    cnt_d = rx_data;
                    if (rx_data == 8'd0) begin
                        state_d = StIdle;
                    end else if (is_rd_q) begin
                        state_d = StRdFetch;
                    end else begin
                        state_d = StWrData;
                    end
                end
            end
            StWrData: begin
                if (rx_valid) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            StRdFetch: begin
                err_d   = rx_valid;
                ram_re  = 1'b1;
                state_d = StRdWait;
            end
            StRdWait: begin
                err_d      = rx_valid;
                tx_data_d  = rd_data_q;
                tx_valid_d = 1'b1;
                state_d    = StRdSend;
            end
            StRdSend: begin
                err_d = rx_valid;
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 1'b1;
                    cnt_d      = cnt_q - 8'd1;
                    state_d    = (cnt_q == 8'd1) ? StIdle : StRdFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = StIdle;
        end
    end

    always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
        if (ext_rst) begin
            state_q    <= StIdle;
            is_rd_q    <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= 8'd0;
            tmo_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_rd_q    <= is_rd_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= err_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    // Byte RAM: no reset so contents survive ext_rst.
    always_ff @(posedge ext_clk_25m) begin
        if (ram_we) begin
            mem_q[addr_q] <= rx_data;
        end
        if (ram_re) begin
            rd_data_q <= mem_q[addr_q];
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;

endmodule
